// File: rtl/adc_pair_averager_if.sv
// Sample-in / average-out bundle for the dual-channel pair averager.
// The master side is the XADC stream plus control, and the slave side is the averager.
interface adc_pair_averager_if #(
    parameter int LOG2_AVG = 4,
    parameter int DATA_W   = 12
);
    logic                  new_data;
    logic [DATA_W-1:0]     data_a;
    logic [DATA_W-1:0]     data_b;
    logic [DATA_W-1:0]     limit;
    logic                  fault_clear;
    logic                  avg_valid;
    logic [DATA_W-1:0]     avg_a;
    logic [DATA_W-1:0]     avg_b;
    logic [DATA_W-1:0]     peak_a;
    logic [DATA_W-1:0]     peak_b;
    logic                  fault;
    logic [LOG2_AVG:0]     win_count;

    modport master (
        output new_data, data_a, data_b, limit, fault_clear,
        input  avg_valid, avg_a, avg_b, peak_a, peak_b, fault, win_count
    );

    modport slave (
        input  new_data, data_a, data_b, limit, fault_clear,
        output avg_valid, avg_a, avg_b, peak_a, peak_b, fault, win_count
    );
endinterface

// File: rtl/adc_pair_averager.sv
// Boxcar averager for paired XADC samples: each channel accumulates
// 2^LOG2_AVG samples and publishes the floor average plus the window peak.
// A sticky fault is set whenever a raw sample on either channel exceeds the limit.
module adc_pair_averager #(
    parameter int LOG2_AVG = 4,
    parameter int DATA_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    adc_pair_averager_if.slave bus
);
    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_avg_valid;
    logic              r_fault;
    logic              w_last;
    logic [DATA_W-1:0] w_sample [2];
    logic [DATA_W-1:0] w_avg    [2];
    logic [DATA_W-1:0] w_peak   [2];
    logic [1:0]        w_over;

    assign w_sample[0] = bus.data_a;
    assign w_sample[1] = bus.data_b;

    // The strobe that closes the window; its sample still belongs to this window.
    assign w_last = bus.new_data && (r_cnt == LAST_CNT);

    // Both channels are identical: one accumulator, running peak and output pair each.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
            logic [ACC_W-1:0]  r_acc;
            logic [DATA_W-1:0] r_pk;
            logic [DATA_W-1:0] r_avg;
            logic [DATA_W-1:0] r_peak;
            logic [ACC_W-1:0]  w_sum;
            logic [DATA_W-1:0] w_pk_next;

            // The accumulator is wide enough that including the closing sample cannot overflow.
            assign w_sum     = r_acc + ACC_W'(w_sample[gi]);
            assign w_pk_next = (w_sample[gi] > r_pk) ? w_sample[gi] : r_pk;
            assign w_over[gi] = bus.new_data && (w_sample[gi] > bus.limit);
            assign w_avg[gi]  = r_avg;
            assign w_peak[gi] = r_peak;

            // Accumulate and track the peak mid-window, then publish and restart on the last sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc  <= '0;
                    r_pk   <= '0;
                    r_avg  <= '0;
                    r_peak <= '0;
                end else if (w_last) begin
                    r_avg  <= DATA_W'(w_sum >> LOG2_AVG);
                    r_peak <= w_pk_next;
                    r_acc  <= '0;
                    r_pk   <= '0;
                end else if (bus.new_data) begin
                    r_acc  <= w_sum;
                    r_pk   <= w_pk_next;
                end
            end
        end
    endgenerate

    // Count samples in the window and issue a single-cycle valid when it closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= w_last;
            if (w_last) begin
                r_cnt <= '0;
            end else if (bus.new_data) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Sticky over-limit flag; a new violation outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (|w_over) begin
            r_fault <= 1'b1;
        end else if (bus.fault_clear) begin
            r_fault <= 1'b0;
        end
    end

    assign bus.avg_valid = r_avg_valid;
    assign bus.avg_a     = w_avg[0];
    assign bus.avg_b     = w_avg[1];
    assign bus.peak_a    = w_peak[0];
    assign bus.peak_b    = w_peak[1];
    assign bus.fault     = r_fault;
    assign bus.win_count = r_cnt;
endmodule

// File: tb/tb_adc_pair_averager.sv
// Directed bench for adc_pair_averager: one LOG2_AVG=4 instance and one LOG2_AVG=0
// instance share the same stimulus; expected values are hand-computed constants.
module tb_adc_pair_averager;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   vcnt4;
    int   vcnt0;
    int   v_start;

    adc_pair_averager_if #(.LOG2_AVG(4), .DATA_W(12)) bus4 ();
    adc_pair_averager_if #(.LOG2_AVG(0), .DATA_W(12)) bus0 ();

    adc_pair_averager #(.LOG2_AVG(4), .DATA_W(12)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    adc_pair_averager #(.LOG2_AVG(0), .DATA_W(12)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count avg_valid pulses shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus4.avg_valid) vcnt4++;
        if (bus0.avg_valid) vcnt0++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic set_inputs(input logic nd, input int a, input int b);
        bus4.new_data = nd; bus4.data_a = 12'(a); bus4.data_b = 12'(b);
        bus0.new_data = nd; bus0.data_a = 12'(a); bus0.data_b = 12'(b);
    endtask

    task automatic set_ctrl(input int lim, input logic clr);
        bus4.limit = 12'(lim); bus4.fault_clear = clr;
        bus0.limit = 12'(lim); bus0.fault_clear = clr;
    endtask

    // Present one strobe at a falling edge; returns at the next falling edge with outputs settled.
    task automatic drive(input int a, input int b);
        set_inputs(1'b1, a, b);
        @(negedge clk);
        set_inputs(1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        set_inputs(1'b0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; vcnt4 = 0; vcnt0 = 0;
        rst_n = 1'b0;
        set_inputs(1'b0, 0, 0);
        set_ctrl(4095, 1'b0);

        // Reset held with strobes active
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive(4000, 4000);
        check("rst_valid", bus4.avg_valid, 0);
        check("rst_wincnt", bus4.win_count, 0);
        check("rst_avg_a", bus4.avg_a, 0);
        check("rst_fault", bus4.fault, 0);
        rst_n = 1'b1;
        idle(20);
        check("idle_avg_b", bus4.avg_b, 0);
        check("idle_peak_a", bus4.peak_a, 0);
        check("idle_peak_b", bus4.peak_b, 0);
        check("idle_valid_cnt4", vcnt4, 0);
        check("idle_valid_cnt0", vcnt0, 0);

        // Constant input, strobes 3 cycles apart
        v_start = vcnt4;
        for (int i = 0; i < 16; i++) begin
            drive(100, 4095);
            if (i == 4) check("const_wincnt5", bus4.win_count, 5);
            if (i < 15) idle(2);
        end
        check("const_valid", bus4.avg_valid, 1);
        check("const_avg_a", bus4.avg_a, 100);
        check("const_avg_b", bus4.avg_b, 4095);
        check("const_peak_a", bus4.peak_a, 100);
        check("const_peak_b", bus4.peak_b, 4095);
        check("const_wincnt0", bus4.win_count, 0);
        idle(3);
        check("const_one_pulse", vcnt4 - v_start, 1);

        // Truncation and peak, back-to-back strobes
        for (int i = 0; i < 16; i++) drive(i, (i == 0) ? 1 : 0);
        check("trunc_valid", bus4.avg_valid, 1);
        check("trunc_avg_a", bus4.avg_a, 7);
        check("trunc_peak_a", bus4.peak_a, 15);
        check("trunc_avg_b", bus4.avg_b, 0);
        check("trunc_peak_b", bus4.peak_b, 1);
        drive(0, 0);
        check("trunc_no_double_valid", bus4.avg_valid, 0);
        check("trunc_hold_avg_a", bus4.avg_a, 7);
        for (int i = 1; i < 16; i++) drive(0, 0);
        check("zero_valid", bus4.avg_valid, 1);
        check("zero_peak_a", bus4.peak_a, 0);
        check("zero_avg_a", bus4.avg_a, 0);

        // Mid-window reset discards the partial window
        idle(2);
        for (int i = 0; i < 10; i++) drive(4000, 0);
        check("mid_wincnt10", bus4.win_count, 10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_wincnt", bus4.win_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 16; i++) drive(16, 0);
        check("mid_valid", bus4.avg_valid, 1);
        check("mid_avg_a", bus4.avg_a, 16);
        check("mid_peak_a", bus4.peak_a, 16);

        // LOG2_AVG = 0 instance: every strobe yields its own average
        idle(2);
        drive(5, 0);
        check("n1_valid0", bus0.avg_valid, 1);
        check("n1_avg0", bus0.avg_a, 5);
        check("n1_peak0", bus0.peak_a, 5);
        drive(9, 0);
        check("n1_valid1", bus0.avg_valid, 1);
        check("n1_avg1", bus0.avg_a, 9);
        check("n1_peak1", bus0.peak_a, 9);
        drive(3, 0);
        check("n1_valid2", bus0.avg_valid, 1);
        check("n1_avg2", bus0.avg_a, 3);
        check("n1_peak2", bus0.peak_a, 3);
        idle(1);
        check("n1_valid_drop", bus0.avg_valid, 0);

        // Fault behaviour
        set_ctrl(2000, 1'b0);
        drive(2000, 2000);
        check("flt_equal", bus4.fault, 0);
        drive(2001, 0);
        check("flt_set_a", bus4.fault, 1);
        idle(50);
        check("flt_sticky", bus4.fault, 1);
        set_ctrl(2000, 1'b1);
        drive(2500, 0);
        check("flt_set_wins", bus4.fault, 1);
        set_ctrl(2000, 1'b1);
        idle(1);
        check("flt_clear", bus4.fault, 0);
        set_ctrl(2000, 1'b0);
        idle(1);
        drive(0, 2001);
        check("flt_set_b", bus4.fault, 1);
        check("flt_set_b_n1", bus0.fault, 1);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adc_pair_averager.md
# adc_pair_averager

Downstream consumer of the dual-channel XADC sample stream. On each `new_data` strobe it takes one `data_a`/`data_b` pair and boxcar-averages a fixed power-of-two window per channel, tracking the per-window peak. It also raises a sticky over-limit fault on any raw sample above a programmable threshold. Outputs feed the coil-current control loop and the protection logic.

## Interface
Parameters:
- `LOG2_AVG`, default 4: window length N = 2^LOG2_AVG sample pairs; legal range 0..8.
- `DATA_W`, default 12: sample width, matching XADC data.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `new_data`  in  1  one-cycle strobe: `data_a`/`data_b` are valid this cycle.
- `data_a`  in  DATA_W  channel A sample, unsigned.
- `data_b`  in  DATA_W  channel B sample, unsigned.
- `limit`  in  DATA_W  over-limit threshold, unsigned, quasi-static.
- `fault_clear`  in  1  level/pulse; clears the sticky fault.
- `avg_valid`  out  1  one-cycle strobe: `avg_a`, `avg_b`, `peak_a` and `peak_b` updated.
- `avg_a`  out  DATA_W  channel A window average.
- `avg_b`  out  DATA_W  channel B window average.
- `peak_a`  out  DATA_W  channel A window maximum.
- `peak_b`  out  DATA_W  channel B window maximum.
- `fault`  out  1  sticky over-limit flag.
- `win_count`  out  LOG2_AVG+1  samples accumulated in the current window (debug).

## Operation
- Accumulators `acc_a` and `acc_b` are DATA_W+LOG2_AVG bits wide, so they cannot overflow (max N·(2^DATA_W−1)).
- Running peaks `pk_a` and `pk_b` are DATA_W bits wide. Counter `cnt` is 0..N−1.
- Each `new_data` cycle that is not the last sample of the window (cnt < N−1):
  - acc += sample.
  - pk = max(pk, sample).
  - cnt += 1.
- On `new_data` with cnt == N−1 (last sample):
  - `avg_a` <= (acc_a + data_a) >> LOG2_AVG, floor/truncating; same for B.
  - `peak_a` <= max(pk_a, data_a); same for B.
  - `avg_valid` <= 1.
  - acc, pk and cnt reset to 0. The new window starts empty, and the last sample belongs to the completed window.
- Cycles without `new_data`: accumulators, peaks and counter hold; `avg_valid` is 0.
- Averages and peaks hold their last values between `avg_valid` strobes.
- LOG2_AVG = 0: every `new_data` produces `avg_valid`, with `avg` = `peak` = the sample.
- Fault:
  - Set condition: `new_data` && (`data_a` > `limit` || `data_b` > `limit`). Strict greater-than, so equality does not fault.
  - `fault` goes to 1 the next cycle and stays 1 until `fault_clear`.
  - If set and clear happen in the same cycle, set wins and `fault` stays 1.
  - The fault does not gate averaging.
- `win_count` = cnt.

## Timing
- Reset (`rst_n` low, asynchronous): all of the following go to 0 immediately and stay 0 while `rst_n` is low:
  - `avg_valid`, `avg_a`, `avg_b`, `peak_a`, `peak_b`, `fault`, `win_count`
  - internal acc, pk, cnt.
- Reset mid-window discards the partial window. The first window after release needs N full strobes.
- Latency:
  - `avg_valid` asserts one cycle after the N-th `new_data`, with outputs valid in that same cycle.
  - `fault` asserts one cycle after the offending strobe.
- `new_data` may assert on consecutive cycles with no bubble required. Back-to-back windows produce `avg_valid` exactly every N strobes.
- `avg_valid` is high for exactly one cycle per window, never two consecutive cycles unless LOG2_AVG = 0 with back-to-back strobes.
- `limit` changes take effect on the next strobe. No `limit` registering is required.

## Test plan
- Reset/idle: hold `rst_n` low with strobes active, then release and idle 20 cycles → all outputs 0, no `avg_valid`.
- Constant input: LOG2_AVG = 4, 16 strobes with A = 100, B = 4095, strobes spaced 3 cycles apart → single `avg_valid` one cycle after the 16th strobe, `avg_a` = 100, `avg_b` = 4095, `peak_a` = 100, `peak_b` = 4095, `win_count` returns to 0.
- Truncation and peak: 16 strobes with A = 0..15 back-to-back, B = 1 on the first strobe and 0 thereafter → `avg_a` = 7 (120/16), `peak_a` = 15, `avg_b` = 0, `peak_b` = 1. A second window of all-zero samples gives `peak_a` = 0, confirming the peak resets.
- Mid-window reset: 10 strobes of A = 4000, assert `rst_n` low, release, then 16 strobes of A = 16 → `avg_a` = 16, with no contribution from the pre-reset samples.
- Fault:
  - `limit` = 2000 and A = 2000 → `fault` stays 0.
  - A = 2001 → `fault` = 1 the next cycle and stays 1 through 50 idle cycles.
  - `fault_clear` in the same cycle as an over-limit strobe → `fault` stays 1.
  - `fault_clear` alone → `fault` = 0 the next cycle.
- LOG2_AVG = 0 instance: back-to-back strobes 5, 9, 3 → `avg_valid` high for 3 consecutive cycles, `avg_a` = 5, 9, 3 and `peak_a` matching.
